mult_unit: RTL and testbench
============================

# mult_unit

Parametrised, fully pipelined integer multiplier for the CPU execute stage, covering the four RV32M multiply operations (MUL, MULH, MULHSU, MULHU). It generalises the fixed 32x32 signed DSP multiplier: width and pipeline depth are parameters, per-operand signedness is selected per operation, and the result half is selected per operation. A valid/ready handshake supports backpressure and flush, and an opaque tag travels with each operation for writeback routing.

## Interface
- `WIDTH`, 32: operand width and result width.
- `LATENCY`, 3: cycles from accept to `out_valid`; legal range 2..6.
- `TAG_W`, 5: width of the pass-through tag (destination register index).

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept this cycle.
- `in_op`  in  2  operation select, encoded in `mult_pkg`.
- `in_a`  in  WIDTH  rs1 operand.
- `in_b`  in  WIDTH  rs2 operand.
- `in_tag`  in  TAG_W  tag returned with the result.
- `flush`  in  1  kill all in-flight operations.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_result`  out  WIDTH  selected product half.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- Operation encodings:
  - `MUL`=0: both operands signed, low half.
  - `MULH`=1: both signed, high half.
  - `MULHSU`=2: a signed, b unsigned, high half.
  - `MULHU`=3: both unsigned, high half.
- Operand formation: each operand is extended to WIDTH+1 bits, sign- or zero-extended per its signedness. The signed (WIDTH+1)x(WIDTH+1) product is truncated to 2*WIDTH bits. The low half is bits [WIDTH-1:0]; the high half is bits [2*WIDTH-1:WIDTH].
- Accept: a handshake occurs when `in_valid && in_ready` in a cycle with `flush` low. The operands, op and tag are captured in pipeline stage 0.
- Pipeline: LATENCY register stages, each with a valid bit. The op and tag ride along in parallel with the data.
- Stall: `stall = out_valid && !out_ready`.
  - While stalled, every stage holds its contents.
  - `in_ready = !reset && !stall`, a combinational signal.
  - When not stalled, all stages advance together, bubbles included.
- Flush: `flush` high clears every valid bit at the next edge. A same-cycle handshake is discarded, because flush wins. Data registers need not be cleared. `out_valid` is 0 in the cycle after flush.
- Output: `out_result` and `out_tag` come from the last stage and are held stable while `out_valid && !out_ready`.
- Reset: all valid bits, `out_result` and `out_tag` are 0, and `in_ready` is 0 while `reset` is high. Asserting reset mid-operation discards all in-flight work, and nothing re-emerges after release.

## Timing
- Latency: accept at edge N gives `out_valid` high after edge N+LATENCY-1 when unstalled, i.e. in the LATENCY-th cycle counting the accept cycle as 1.
- Throughput: one operation per cycle when unstalled. Back-to-back results appear on consecutive cycles.
- A stall of k cycles delays every in-flight result by exactly k cycles. No result is lost or duplicated.
- Simultaneous `out_ready` high and a new accept: the pipeline advances, and the new op enters stage 0 in the same edge.
- `out_valid` must never depend combinationally on `in_valid`.
- Multiply placement:
  - The multiply occurs between stage 0 and stage LATENCY-2, so the tool can map it to DSP input, pipe and output registers.
  - Half-selection is registered into the final stage.

## Structure
- `mult_pkg` holds:
  - the `mult_op_e` 2-bit enum (MUL/MULH/MULHSU/MULHU);
  - the `op_a_signed()` and `op_b_signed()` functions;
  - the `op_high()` helper.
- Sub-module `mult_core`:
  - a signed (WIDTH+1)x(WIDTH+1) multiplier with `LATENCY-1` internal register stages and a common enable `ce = !stall`;
  - no handshake logic, only data;
  - inferred multiply, so vendor DSP primitives are picked by synthesis.
- `mult_unit` owns the valid/op/tag shift chain, stall and flush logic, and the final half-select register.

## Test plan
- Signedness:
  - MUL 7 × 0xFFFFFFFD (−3) -> `out_result`=0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - Each result appears exactly LATENCY cycles after accept.
- Throughput: 8 back-to-back MULs (a=i, b=i+1) with tags 0..7, `out_ready`=1 -> 8 consecutive valid cycles with results i*(i+1) and tags in order.
- Backpressure: hold `out_ready`=0 for 5 cycles during the stream -> `in_ready`=0 throughout, output held stable, no loss or duplication, order preserved.
- Flush: accept 3 ops, assert `flush` together with a 4th `in_valid` -> no `out_valid` for 2*LATENCY cycles. The next accepted op returns normally.
- Reset mid-operation: accept 2 ops, pulse `reset` asynchronously between edges -> `out_valid`, `out_result` and `out_tag` go to 0 immediately, and no stale result appears after release.
- Parameter sweep: WIDTH=16 and LATENCY=2 and 6 with random ops -> results match a reference model with 2*WIDTH product-half selection.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and operation decode for the RV32M-style pipelined multiplier.
// Signedness and half-selection per operation live here so core and top agree.
package mult_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_op_e;

  function automatic logic op_a_signed(input mult_op_e op);
    return op != MULHU;
  endfunction

  function automatic logic op_b_signed(input mult_op_e op);
    return (op == MUL) || (op == MULH);
  endfunction

  function automatic logic op_high(input mult_op_e op);
    return op != MUL;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Data-only signed (WIDTH+1)x(WIDTH+1) multiplier with LATENCY-1 register stages.
// Operand registers, then LATENCY-2 product registers, so synthesis can retime into DSP blocks.
module mult_core #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    i_ce,
  input  logic signed [WIDTH:0]   i_a,
  input  logic signed [WIDTH:0]   i_b,
  output logic signed [2*WIDTH+1:0] o_prod
);

  localparam int PW = 2*WIDTH + 2;

  logic signed [WIDTH:0] r_a;
  logic signed [WIDTH:0] r_b;
  logic signed [PW-1:0]  w_prod;

  // NOTE: pure datapath registers carry no reset; validity is tracked by the owner of the pipeline.
  always_ff @(posedge clk) begin
    if (i_ce) begin
      r_a <= i_a;
      r_b <= i_b;
    end
  end

  assign w_prod = r_a * r_b;

  generate
    if (LATENCY == 2) begin : g_comb_out
      assign o_prod = w_prod;
    end else begin : g_pipe
      logic signed [PW-1:0] r_p [LATENCY-2];

      always_ff @(posedge clk) begin
        if (i_ce) begin
          r_p[0] <= w_prod;
          for (int i = 1; i < LATENCY-2; i++) begin
            r_p[i] <= r_p[i-1];
          end
        end
      end

      assign o_prod = r_p[LATENCY-3];
    end
  endgenerate

endmodule

// File: rtl/mult_unit.sv
// Pipelined RV32M multiply unit: valid/op/tag chain, stall and flush control around mult_core,
// and the registered product-half select that forms the final stage.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = 2*WIDTH + 2;

  logic                  w_stall;
  logic                  w_accept;
  mult_op_e              w_op;
  logic signed [WIDTH:0] w_a;
  logic signed [WIDTH:0] w_b;
  logic signed [PW-1:0]  w_prod;
  logic                  w_unused_prod;

  logic [LATENCY-1:0] r_vld;
  mult_op_e           r_op  [LATENCY-1];
  logic [TAG_W-1:0]   r_tag [LATENCY-1];
  logic [WIDTH-1:0]   r_result;
  logic [TAG_W-1:0]   r_out_tag;

  assign w_op     = mult_op_e'(in_op);
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !reset && !w_stall;
  assign w_accept = in_valid && in_ready && !flush;

  assign w_a = {op_a_signed(w_op) & in_a[WIDTH-1], in_a};
  assign w_b = {op_b_signed(w_op) & in_b[WIDTH-1], in_b};

  mult_core #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_core (
    .clk   (clk),
    .i_ce  (!w_stall),
    .i_a   (w_a),
    .i_b   (w_b),
    .o_prod(w_prod)
  );

  // The two extension bits above 2*WIDTH are discarded by the truncation.
  assign w_unused_prod = ^w_prod[PW-1:2*WIDTH];

  // NOTE: sequential state always uses non-blocking assignment so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else if (!w_stall) begin
      r_vld <= {r_vld[LATENCY-2:0], w_accept};
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_op[0]  <= w_op;
      r_tag[0] <= in_tag;
      for (int i = 1; i < LATENCY-1; i++) begin
        r_op[i]  <= r_op[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result  <= '0;
      r_out_tag <= '0;
    end else if (!w_stall) begin
      r_result  <= op_high(r_op[LATENCY-2]) ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
      r_out_tag <= r_tag[LATENCY-2];
    end
  end

  assign out_valid  = r_vld[LATENCY-1];
  assign out_result = r_result;
  assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: scoreboard of expected results checked on every output handshake,
// plus scenario tasks for signedness, throughput, backpressure, flush, reset and a 16-bit sweep.
module tb_mult_unit;

  localparam int W  = 32;
  localparam int L  = 3;
  localparam int TW = 5;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  logic          s_valid;
  logic [1:0]    s_op;
  logic [15:0]   s_a;
  logic [15:0]   s_b;
  logic [TW-1:0] s_tag;
  logic          s2_ready, s2_valid, s6_ready, s6_valid;
  logic [15:0]   s2_result, s6_result;
  logic [TW-1:0] s2_tag, s6_tag;

  exp_t sb[$];
  exp_t sb2[$];
  exp_t sb6[$];
  exp_t m_e, m_e2, m_e6;

  int passed = 0;
  int total  = 0;

  mult_unit #(.WIDTH(W), .LATENCY(L), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  mult_unit #(.WIDTH(16), .LATENCY(2), .TAG_W(TW)) dut_w16_l2 (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s2_ready), .in_op(s_op),
    .in_a(s_a), .in_b(s_b), .in_tag(s_tag), .flush(1'b0), .out_valid(s2_valid),
    .out_ready(1'b1), .out_result(s2_result), .out_tag(s2_tag)
  );

  mult_unit #(.WIDTH(16), .LATENCY(6), .TAG_W(TW)) dut_w16_l6 (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s6_ready), .in_op(s_op),
    .in_a(s_a), .in_b(s_b), .in_tag(s_tag), .flush(1'b0), .out_valid(s6_valid),
    .out_ready(1'b1), .out_result(s6_result), .out_tag(s6_tag)
  );

  // Reference: extend per signedness, multiply in 64-bit arithmetic, pick the requested half.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    longint          xa, xb, p;
    longint unsigned up;
    logic [31:0]     mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
    xa = longint'({32'd0, a});
    xb = longint'({32'd0, b});
    if (op != 2'd3 && a[w-1]) xa = xa - (longint'(1) << w);
    if ((op == 2'd0 || op == 2'd1) && b[w-1]) xb = xb - (longint'(1) << w);
    p  = xa * xb;
    up = p;
    if (op == 2'd0) return up[31:0] & mask;
    return 32'(up >> w) & mask;
  endfunction

  // Output monitors: every handshake pops and compares one scoreboard entry.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL main_unexpected: got res=%h tag=%0d, expected no result", out_result, out_tag);
      end else begin
        m_e = sb.pop_front();
        if (out_result !== m_e.res || out_tag !== m_e.tag)
          $display("FAIL main_result: got res=%h tag=%0d, expected res=%h tag=%0d",
                   out_result, out_tag, m_e.res, m_e.tag);
        else passed++;
      end
    end
    if (s2_valid) begin
      total++;
      if (sb2.size() == 0) begin
        $display("FAIL w16_l2_unexpected: got res=%h tag=%0d", s2_result, s2_tag);
      end else begin
        m_e2 = sb2.pop_front();
        if ({16'd0, s2_result} !== m_e2.res || s2_tag !== m_e2.tag)
          $display("FAIL w16_l2_result: got res=%h tag=%0d, expected res=%h tag=%0d",
                   s2_result, s2_tag, m_e2.res, m_e2.tag);
        else passed++;
      end
    end
    if (s6_valid) begin
      total++;
      if (sb6.size() == 0) begin
        $display("FAIL w16_l6_unexpected: got res=%h tag=%0d", s6_result, s6_tag);
      end else begin
        m_e6 = sb6.pop_front();
        if ({16'd0, s6_result} !== m_e6.res || s6_tag !== m_e6.tag)
          $display("FAIL w16_l6_result: got res=%h tag=%0d, expected res=%h tag=%0d",
                   s6_result, s6_tag, m_e6.res, m_e6.tag);
        else passed++;
      end
    end
  end

  // Offers one op; returns at posedge+1 after the accepting edge (or after a bounded wait).
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    int   n   = 0;
    bit   acc = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        e.res = ref_mul(op, a, b, 32);
        e.tag = tag;
        sb.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      $display("FAIL send_timeout: got no accept in %0d cycles, expected accept (tag %0d)", n, tag);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb.size() != 0) $display("FAIL %s_drained: got %0d pending, expected 0", name, sb.size());
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
    if (out_result !== '0) $display("FAIL reset_out_result: got %h expected 0", out_result); else passed++;
    if (out_tag !== '0) $display("FAIL reset_out_tag: got %h expected 0", out_tag); else passed++;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else passed++;
  endtask

  task automatic test_signedness();
    logic [1:0]  vop [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] va  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vx  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      int lat  = 1;
      bit seen = 1'b0;
      send(vop[i], va[i], vb[i], 5'(i + 1));
      while (!seen && lat <= 10) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
        else begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
      total += 2;
      if (lat !== L) $display("FAIL sign_latency_op%0d: got %0d cycles expected %0d", i, lat, L);
      else passed++;
      if (out_result !== vx[i]) $display("FAIL sign_value_op%0d: got %h expected %h", i, out_result, vx[i]);
      else passed++;
      @(posedge clk);
      #1;
    end
    check_drained("signedness");
  endtask

  task automatic test_throughput();
    int run = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(2'd0, 32'(i), 32'(i + 1), 5'(i));
      end
      begin
        int waitn = 0;
        do begin
          @(negedge clk);
          waitn++;
        end while (!out_valid && waitn < 30);
        while (out_valid && run < 20) begin
          run++;
          @(negedge clk);
        end
      end
    join
    total++;
    if (run !== 8) $display("FAIL throughput_run: got %0d consecutive valid cycles expected 8", run);
    else passed++;
    idle(2);
    check_drained("throughput");
  endtask

  task automatic test_backpressure();
    fork
      begin
        for (int i = 0; i < 8; i++) send(2'(i), $urandom, $urandom, 5'(8 + i));
      end
      begin
        int          waitn = 0;
        logic [31:0] snap_r;
        logic [4:0]  snap_t;
        do begin
          @(negedge clk);
          waitn++;
        end while (!out_valid && waitn < 30);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap_r = out_result;
        snap_t = out_tag;
        for (int k = 0; k < 5; k++) begin
          total += 4;
          if (in_ready !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b expected 0", k, in_ready); else passed++;
          if (out_valid !== 1'b1) $display("FAIL bp_out_valid_c%0d: got %b expected 1", k, out_valid); else passed++;
          if (out_result !== snap_r) $display("FAIL bp_hold_result_c%0d: got %h expected %h", k, out_result, snap_r); else passed++;
          if (out_tag !== snap_t) $display("FAIL bp_hold_tag_c%0d: got %0d expected %0d", k, out_tag, snap_t); else passed++;
          if (k < 4) begin
            @(posedge clk);
            @(negedge clk);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(L + 3);
    check_drained("backpressure");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) send(2'd0, 32'(100 + i), 32'd3, 5'(20 + i));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_a     = 32'd9;
    in_b     = 32'd9;
    in_tag   = 5'd23;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    for (int k = 0; k < 2*L; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL flush_quiet_c%0d: got out_valid %b expected 0", k, out_valid);
      else passed++;
      @(posedge clk);
      #1;
    end
    send(2'd0, 32'd5, 32'd6, 5'd24);
    idle(L + 2);
    check_drained("flush");
  endtask

  task automatic test_reset_mid();
    send(2'd1, 32'h1234_5678, 32'h7654_3210, 5'd25);
    send(2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd26);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total += 4;
    if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); else passed++;
    if (out_result !== '0) $display("FAIL rst_mid_out_result: got %h expected 0", out_result); else passed++;
    if (out_tag !== '0) $display("FAIL rst_mid_out_tag: got %0d expected 0", out_tag); else passed++;
    if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready); else passed++;
    sb.delete();
    @(posedge clk);
    #3 reset = 1'b0;
    for (int k = 0; k < 2*L; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL rst_mid_stale_c%0d: got out_valid %b expected 0", k, out_valid);
      else passed++;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_param_sweep();
    logic [15:0] corner [4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001};
    exp_t        e;
    for (int i = 0; i < 32; i++) begin
      s_valid = 1'b1;
      s_op    = 2'($urandom_range(0, 3));
      s_a     = (i < 4) ? corner[i] : 16'($urandom);
      s_b     = (i < 4) ? corner[3 - i] : 16'($urandom);
      s_tag   = 5'(i);
      e.res   = ref_mul(s_op, {16'd0, s_a}, {16'd0, s_b}, 16);
      e.tag   = s_tag;
      sb2.push_back(e);
      sb6.push_back(e);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    idle(10);
    total += 2;
    if (sb2.size() != 0) $display("FAIL w16_l2_drained: got %0d pending expected 0", sb2.size()); else passed++;
    if (sb6.size() != 0) $display("FAIL w16_l6_drained: got %0d pending expected 0", sb6.size()); else passed++;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    s_valid   = 1'b0;
    s_op      = 2'd0;
    s_a       = '0;
    s_b       = '0;
    s_tag     = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_signedness();
    test_throughput();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_param_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
